// File: rtl/clk_lock_qualifier.sv
// clk_lock_qualifier
//   Qualifies the raw asynchronous locked flag of the 10 MHz reference PLL/MMCM.
//   Lock is accepted only after it has been stable for QUAL_CYCLES. A loss of lock
//   is reported within three edges, counted (saturating) and latched in a sticky flag.
//   After a loss, requalification waits out a HOLDOFF_CYCLES dwell.
//   Optional feature macro: CLK_LOCK_QUAL_AUTO_RELOCK_EN. When defined, the block
//   issues a RST_PULSE_CYC-wide pll_rst_req pulse after lock has been missing for
//   TIMEOUT_CYCLES cycles.
`timescale 1ns/1ps

module clk_lock_qualifier #(
  parameter int QUAL_CYCLES    = 1000000,
  parameter int HOLDOFF_CYCLES = 100000,
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int RST_PULSE_CYC  = 16,
  parameter int CNT_W          = 24,
  parameter int LOSS_CNT_W     = 16
) (
  input  logic                  gclk10m_buf,
  input  logic                  rst,
  input  logic                  pll_locked_raw,
  input  logic                  clr_sticky,
  output logic                  gclk10m_locked,
  output logic                  lock_lost_sticky,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic [1:0]            lock_state,
  output logic                  pll_rst_req
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_QUALIFY  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOFF  = 2'd3
  } state_t;

  // Timer must be able to hold every terminal count it is compared against.
  if ((64'(QUAL_CYCLES) - 64'd1)    >= (64'd1 << CNT_W) ||
      (64'(HOLDOFF_CYCLES) - 64'd1) >= (64'd1 << CNT_W) ||
      (64'(TIMEOUT_CYCLES) - 64'd1) >= (64'd1 << CNT_W) ||
      QUAL_CYCLES < 1 || HOLDOFF_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
      RST_PULSE_CYC < 1) begin : g_bad_params
    $error("clk_lock_qualifier: CNT_W too narrow or a cycle parameter below 1");
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic                  sync1_q, sync1_d;
  logic                  lk_s_q, lk_s_d;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  locked_q, locked_d;
  logic                  sticky_q, sticky_d;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic                  loss_evt;
  logic                  relock_hold;

  // Two-flop synchroniser inputs: only lk_s_q is ever looked at by the logic.
  always_comb begin
    sync1_d = pll_locked_raw;
    lk_s_d  = sync1_q;
  end

`ifdef CLK_LOCK_QUAL_AUTO_RELOCK_EN
  localparam int PW = (RST_PULSE_CYC > 1) ? $clog2(RST_PULSE_CYC) : 1;

  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [PW-1:0]    pulse_cnt_q, pulse_cnt_d;
  logic             rst_req_q, rst_req_d;

  // Stall timeout: count time without lock, then emit a fixed-width PLL reset pulse.
  always_comb begin
    tmo_d       = tmo_q;
    pulse_cnt_d = pulse_cnt_q;
    rst_req_d   = rst_req_q;
    if (rst_req_q) begin
      tmo_d = '0;
      if (pulse_cnt_q == PW'(RST_PULSE_CYC - 1)) begin
        rst_req_d   = 1'b0;
        pulse_cnt_d = '0;
      end else begin
        pulse_cnt_d = pulse_cnt_q + 1'b1;
      end
    end else if (state_q == ST_UNLOCKED || state_q == ST_QUALIFY) begin
      if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        rst_req_d   = 1'b1;
        pulse_cnt_d = '0;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Timeout registers.
  always_ff @(posedge gclk10m_buf or posedge rst) begin
    if (rst) begin
      tmo_q       <= '0;
      pulse_cnt_q <= '0;
      rst_req_q   <= 1'b0;
    end else begin
      tmo_q       <= tmo_d;
      pulse_cnt_q <= pulse_cnt_d;
      rst_req_q   <= rst_req_d;
    end
  end

  // The FSM is parked in UNLOCKED for as long as the PLL is being reset.
  assign relock_hold = rst_req_d;
  assign pll_rst_req = rst_req_q;
`else
  assign relock_hold = 1'b0;
  assign pll_rst_req = 1'b0;
`endif

  // Lock FSM next state, shared timer and loss-event detection.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    loss_evt = 1'b0;
    unique case (state_q)
      ST_UNLOCKED: begin
        if (lk_s_q) state_d = ST_QUALIFY;
      end
      ST_QUALIFY: begin
        if (!lk_s_q)                                state_d = ST_UNLOCKED;
        else if (cnt_q == CNT_W'(QUAL_CYCLES - 1))  state_d = ST_LOCKED;
        else                                        cnt_d   = cnt_q + 1'b1;
      end
      ST_LOCKED: begin
        if (!lk_s_q) begin
          state_d  = ST_HOLDOFF;
          loss_evt = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) state_d = ST_UNLOCKED;
        else                                     cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_UNLOCKED;
    endcase
    if (relock_hold) state_d = ST_UNLOCKED;
    // A single timer serves every state, so it restarts on any state change.
    if (state_d != state_q) cnt_d = '0;
  end

  // Loss bookkeeping and registered lock level; a loss beats a coincident clear.
  always_comb begin
    sticky_d   = sticky_q;
    loss_cnt_d = loss_cnt_q;
    if (clr_sticky) begin
      sticky_d   = 1'b0;
      loss_cnt_d = '0;
    end
    if (loss_evt) begin
      sticky_d = 1'b1;
      if (loss_cnt_d != '1) loss_cnt_d = loss_cnt_d + 1'b1;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // Main state registers.
  // NOTE: rst is asserted asynchronously but must be released synchronously to
  // gclk10m_buf by the upstream reset bridge; this block does not re-synchronise it.
  always_ff @(posedge gclk10m_buf or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      lk_s_q     <= 1'b0;
      state_q    <= ST_UNLOCKED;
      cnt_q      <= '0;
      locked_q   <= 1'b0;
      sticky_q   <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q    <= sync1_d;
      lk_s_q     <= lk_s_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      locked_q   <= locked_d;
      sticky_q   <= sticky_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign gclk10m_locked   = locked_q;
  assign lock_lost_sticky = sticky_q;
  assign loss_count       = loss_cnt_q;
  assign lock_state       = state_q;

endmodule

// File: tb/tb_clk_lock_qualifier.sv
// tb_clk_lock_qualifier
//   Directed bench for clk_lock_qualifier with QUAL=8, HOLDOFF=4, TIMEOUT=32,
//   RST_PULSE_CYC=16, LOSS_CNT_W=2. Edge numbers in comments count rising edges
//   from the last stimulus change; outputs are sampled 1 ns after each edge.
`timescale 1ns/1ps

module tb_clk_lock_qualifier;

  localparam int QUAL    = 8;
  localparam int HOLDOFF = 4;
  localparam int TIMEOUT = 32;
  localparam int RSTP    = 16;
  localparam int LCW     = 2;

`ifdef CLK_LOCK_QUAL_AUTO_RELOCK_EN
  localparam int RELOCK = 1;
`else
  localparam int RELOCK = 0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           raw;
  logic           clr;
  logic           locked;
  logic           sticky;
  logic [LCW-1:0] loss_count;
  logic [1:0]     lock_state;
  logic           rst_req;

  int checks = 0;
  int errors = 0;

  clk_lock_qualifier #(
    .QUAL_CYCLES   (QUAL),
    .HOLDOFF_CYCLES(HOLDOFF),
    .TIMEOUT_CYCLES(TIMEOUT),
    .RST_PULSE_CYC (RSTP),
    .CNT_W         (8),
    .LOSS_CNT_W    (LCW)
  ) dut (
    .gclk10m_buf     (clk),
    .rst             (rst),
    .pll_locked_raw  (raw),
    .clr_sticky      (clr),
    .gclk10m_locked  (locked),
    .lock_lost_sticky(sticky),
    .loss_count      (loss_count),
    .lock_state      (lock_state),
    .pll_rst_req     (rst_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One loss/recovery cycle from LOCKED: raw low for one cycle, optional clear on the
  // loss edge (edge 3), HOLDOFF edges 3..6, UNLOCKED at 7, QUALIFY at 8, LOCKED at 16.
  task automatic loss_cycle(input string tag, input bit with_clr, input int exp_cnt);
    raw = 1'b0;
    tick(1);
    raw = 1'b1;
    tick(1);
    if (with_clr) clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check({tag, "_state"},  32'(lock_state), 3);
    check({tag, "_sticky"}, 32'(sticky), 1);
    check({tag, "_count"},  32'(loss_count), 32'(exp_cnt));
    tick(13);
    check({tag, "_relock"}, 32'(locked), 1);
  endtask

  initial begin
    rst = 1'b1;
    raw = 1'b0;
    clr = 1'b0;
    tick(3);
    check("rst_locked", 32'(locked), 0);
    check("rst_state",  32'(lock_state), 0);
    check("rst_sticky", 32'(sticky), 0);
    check("rst_count",  32'(loss_count), 0);
    check("rst_req",    32'(rst_req), 0);

    // Test 1: raw=1 before edge 1 -> QUALIFY at edge 3, LOCKED at edge 11.
    rst = 1'b0;
    raw = 1'b1;
    tick(2);
    check("t1_e2_state", 32'(lock_state), 0);
    tick(1);
    check("t1_e3_state", 32'(lock_state), 1);
    tick(7);
    check("t1_e10_state",  32'(lock_state), 1);
    check("t1_e10_locked", 32'(locked), 0);
    tick(1);
    check("t1_e11_state",  32'(lock_state), 2);
    check("t1_e11_locked", 32'(locked), 1);

    // Test 3: loss while LOCKED, raw back after one cycle.
    raw = 1'b0;
    tick(1);
    raw = 1'b1;
    tick(1);
    check("t3_e2_locked", 32'(locked), 1);
    tick(1);
    check("t3_e3_state",  32'(lock_state), 3);
    check("t3_e3_locked", 32'(locked), 0);
    check("t3_e3_sticky", 32'(sticky), 1);
    check("t3_e3_count",  32'(loss_count), 1);
    tick(3);
    check("t3_e6_state", 32'(lock_state), 3);
    tick(1);
    check("t3_e7_state", 32'(lock_state), 0);
    tick(1);
    check("t3_e8_state", 32'(lock_state), 1);
    tick(7);
    check("t3_e15_locked", 32'(locked), 0);
    tick(1);
    check("t3_e16_state",  32'(lock_state), 2);
    check("t3_e16_locked", 32'(locked), 1);

    // Test 6: asynchronous reset while LOCKED, checked before the next edge.
    rst = 1'b1;
    #2;
    check("t6_async_locked", 32'(locked), 0);
    check("t6_async_state",  32'(lock_state), 0);
    check("t6_async_sticky", 32'(sticky), 0);
    check("t6_async_count",  32'(loss_count), 0);
    tick(2);
    rst = 1'b0;

    // Test 2 (also the requalification after test 6): raw stays 1 through release,
    // then is low for the single cycle sampled at edge 6.
    tick(2);
    check("t2_e2_state", 32'(lock_state), 0);
    tick(1);
    check("t2_e3_state", 32'(lock_state), 1);
    tick(2);
    raw = 1'b0;
    tick(1);
    raw = 1'b1;
    tick(1);
    check("t2_e7_state", 32'(lock_state), 1);
    tick(1);
    check("t2_e8_state",  32'(lock_state), 0);
    check("t2_e8_count",  32'(loss_count), 0);
    check("t2_e8_sticky", 32'(sticky), 0);
    tick(8);
    check("t2_e16_state",  32'(lock_state), 1);
    check("t2_e16_locked", 32'(locked), 0);
    tick(1);
    check("t2_e17_locked", 32'(locked), 1);

    // Test 4: clear coinciding with a loss, then saturation, then a lone clear.
    loss_cycle("t4_clr_loss", 1'b1, 1);
    loss_cycle("t4_loss2", 1'b0, 2);
    loss_cycle("t4_loss3", 1'b0, 3);
    loss_cycle("t4_loss4", 1'b0, 3);
    loss_cycle("t4_loss5", 1'b0, 3);
    loss_cycle("t4_loss6", 1'b0, 3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("t4_lone_sticky", 32'(sticky), 0);
    check("t4_lone_count",  32'(loss_count), 0);
    check("t4_lone_locked", 32'(locked), 1);

    // Test 5: raw held 0 after a fresh reset; pulse over edges 32..47 and 80..95.
    rst = 1'b1;
    raw = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(31);
    check("t5_e31_req", 32'(rst_req), 0);
    tick(1);
    check("t5_e32_req", 32'(rst_req), 32'(RELOCK));
    tick(15);
    check("t5_e47_req",   32'(rst_req), 32'(RELOCK));
    check("t5_e47_state", 32'(lock_state), 0);
    tick(1);
    check("t5_e48_req", 32'(rst_req), 0);
    tick(31);
    check("t5_e79_req", 32'(rst_req), 0);
    tick(1);
    check("t5_e80_req", 32'(rst_req), 32'(RELOCK));
    tick(15);
    check("t5_e95_req", 32'(rst_req), 32'(RELOCK));
    tick(1);
    check("t5_e96_req", 32'(rst_req), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
